// File: rtl/cmp_beat_packer.sv
// Repacks partial, low-aligned compressor beats into dense full-width output beats
// and reports the byte length of each completed packet.
module cmp_beat_packer #(
  parameter int DATA_BYTES = 32,
  parameter int CNT_W      = 6,
  parameter int LEN_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [CNT_W-1:0]        s_bytes,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [8*DATA_BYTES-1:0] m_data,
  output logic [CNT_W-1:0]        m_bytes,
  output logic                    m_valid,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic [LEN_W-1:0]        pkt_len,
  output logic                    pkt_done
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int BW = 2 * DW;
  localparam int FW = $clog2(2 * DATA_BYTES + 1);
  localparam logic [FW-1:0]    FULL    = FW'(DATA_BYTES);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t            r_state;
  logic [BW-1:0]     r_buf;
  logic [FW-1:0]     r_fill;
  logic [LEN_W-1:0]  r_runLen;
  logic [LEN_W-1:0]  r_pktLen;
  logic              r_pktDone;

  logic              w_outFire;
  logic              w_inFire;
  logic [CNT_W-1:0]  w_clampBytes;
  logic [DW-1:0]     w_maskedData;
  logic [FW-1:0]     w_outBytes;
  logic [BW-1:0]     w_shiftBuf;
  logic [FW-1:0]     w_shiftFill;
  logic [BW-1:0]     w_mergeBuf;
  logic [FW-1:0]     w_nextFill;
  logic [LEN_W:0]    w_lenSum;
  logic [LEN_W-1:0]  w_nextRunLen;

  assign m_valid  = (r_fill >= FULL) || (r_state == FLUSH);
  assign m_last   = (r_state == FLUSH) && (r_fill <= FULL);
  assign m_data   = r_buf[DW-1:0];
  assign m_bytes  = CNT_W'(w_outBytes);
  assign s_ready  = (r_state == ACCUM) && ((r_fill < FULL) || m_ready);
  assign pkt_len  = r_pktLen;
  assign pkt_done = r_pktDone;

  assign w_outFire    = m_valid && m_ready;
  assign w_inFire     = s_valid && s_ready;
  assign w_clampBytes = (s_bytes > CNT_W'(DATA_BYTES)) ? CNT_W'(DATA_BYTES) : s_bytes;
  assign w_outBytes   = (r_fill >= FULL) ? FULL : r_fill;

  always_comb begin
    w_maskedData = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (CNT_W'(k) < w_clampBytes) begin
        w_maskedData[8*k +: 8] = s_data[8*k +: 8];
      end
    end
  end

  // Output drain happens before the merge, so new bytes land behind what remains.
  assign w_shiftBuf  = w_outFire ? (r_buf >> DW) : r_buf;
  assign w_shiftFill = w_outFire ? (r_fill - w_outBytes) : r_fill;
  assign w_mergeBuf  = w_shiftBuf | ({{DW{1'b0}}, w_maskedData} << {w_shiftFill, 3'b000});
  assign w_nextFill  = w_shiftFill + FW'(w_clampBytes);

  assign w_lenSum     = {1'b0, r_runLen} + (LEN_W+1)'(w_clampBytes);
  assign w_nextRunLen = w_lenSum[LEN_W] ? LEN_MAX : w_lenSum[LEN_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ACCUM;
      r_buf     <= '0;
      r_fill    <= '0;
      r_runLen  <= '0;
      r_pktLen  <= '0;
      r_pktDone <= 1'b0;
    end else begin
      r_pktDone <= 1'b0;
      r_buf     <= w_inFire ? w_mergeBuf : w_shiftBuf;
      r_fill    <= w_inFire ? w_nextFill : w_shiftFill;

      case (r_state)
        ACCUM: begin
          if (w_inFire && s_last) begin
            r_state <= FLUSH;
          end
          if (w_inFire) begin
            r_runLen <= w_nextRunLen;
          end
        end
        FLUSH: begin
          if (w_outFire && m_last) begin
            r_state   <= ACCUM;
            r_fill    <= '0;
            r_pktLen  <= r_runLen;
            r_pktDone <= 1'b1;
            r_runLen  <= '0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_beat_packer.sv
// Directed bench for cmp_beat_packer: output beats and packet lengths are captured
// by a monitor and compared against hand-computed expectations.
module tb_cmp_beat_packer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] s_data = '0;
  logic [5:0]   s_bytes = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [255:0] m_data;
  logic [5:0]   m_bytes;
  logic         m_valid;
  logic         m_last;
  logic         m_ready = 1'b1;
  logic [15:0]  pkt_len;
  logic         pkt_done;

  int assertCount = 0;
  int failCount   = 0;
  int cycle       = 0;
  int readyDrops  = 0;

  logic [255:0] beatData[$];
  int           beatBytes[$];
  int           beatLast[$];
  int           beatCycle[$];
  int           inCycle[$];
  int           lenQ[$];

  cmp_beat_packer dut (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_data),
    .s_bytes (s_bytes),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_bytes (m_bytes),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready),
    .pkt_len (pkt_len),
    .pkt_done(pkt_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Inputs only change just after a rising edge, so the falling edge sees what the next edge consumes.
  always @(negedge clk) begin
    if (reset && m_valid && m_ready) begin
      beatData.push_back(m_data);
      beatBytes.push_back(int'(m_bytes));
      beatLast.push_back(int'(m_last));
      beatCycle.push_back(cycle);
    end
    if (reset && s_valid && s_ready) inCycle.push_back(cycle);
    if (reset && s_valid && !s_ready) readyDrops++;
    if (pkt_done) lenQ.push_back(int'(pkt_len));
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mkBeat(input int start, input int n, input bit junk);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < 32; k++) begin
      if (k < n) v[8*k +: 8] = 8'(start + k);
      else if (junk) v[8*k +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic [255:0] d, input int nb, input logic last);
    int waitCycles;
    waitCycles = 0;
    s_data  = d;
    s_bytes = 6'(nb);
    s_last  = last;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && waitCycles < 100) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!s_ready) checkOutput("s_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    s_bytes = '0;
  endtask

  task automatic waitBeats(input int n);
    int w;
    w = 0;
    while (beatData.size() < n && w < 200) begin
      @(posedge clk);
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clearQueues();
    beatData.delete();
    beatBytes.delete();
    beatLast.delete();
    beatCycle.delete();
    inCycle.delete();
    lenQ.delete();
    readyDrops = 0;
  endtask

  task automatic checkBeat(input string tag, input int idx, input logic [255:0] expData,
                           input int expBytes, input int expLast);
    if (idx < beatData.size()) begin
      checkOutput({tag, "_data"}, beatData[idx], expData);
      checkOutput({tag, "_bytes"}, beatBytes[idx], expBytes);
      checkOutput({tag, "_last"}, beatLast[idx], expLast);
    end else begin
      checkOutput({tag, "_missing"}, 0, 1);
    end
  endtask

  task automatic checkLen(input string tag, input int expLen);
    checkOutput({tag, "_done_count"}, lenQ.size(), 1);
    if (lenQ.size() > 0) checkOutput({tag, "_pkt_len"}, lenQ[0], expLen);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held with random inputs
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'($urandom);
      s_last  = 1'($urandom);
      m_ready = 1'($urandom);
      s_bytes = 6'($urandom_range(0, 32));
      s_data  = {8{$urandom}};
      @(negedge clk);
      checkOutput("rst_m_valid", m_valid, 0);
      checkOutput("rst_m_data", m_data, 0);
      checkOutput("rst_pkt_len", pkt_len, 0);
    end
    checkOutput("rst_m_bytes", m_bytes, 0);
    checkOutput("rst_m_last", m_last, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_bytes = '0;
    s_data  = '0;
    m_ready = 1'b1;
    reset   = 1'b1;
    #1;
    checkOutput("rst_s_ready", s_ready, 1);
    @(posedge clk);
    #1;

    // Four 20-byte partial beats
    clearQueues();
    for (int i = 0; i < 4; i++) applyStimulus(mkBeat(20*i, 20, 1'b1), 20, i == 3);
    waitBeats(3);
    checkOutput("part_beat_count", beatData.size(), 3);
    checkBeat("part_b1", 0, mkBeat(8'h00, 32, 1'b0), 32, 0);
    checkBeat("part_b2", 1, mkBeat(8'h20, 32, 1'b0), 32, 0);
    checkBeat("part_b3", 2, mkBeat(8'h40, 16, 1'b0), 16, 1);
    checkLen("part", 80);

    // Full-rate stream of 32-byte beats
    clearQueues();
    for (int i = 0; i < 8; i++) applyStimulus(mkBeat(32*i, 32, 1'b0), 32, i == 7);
    waitBeats(8);
    checkOutput("full_ready_drops", readyDrops, 0);
    checkOutput("full_beat_count", beatData.size(), 8);
    for (int i = 0; i < 8; i++) begin
      checkBeat($sformatf("full_b%0d", i + 1), i, mkBeat(32*i, 32, 1'b0), 32, (i == 7) ? 1 : 0);
      if (i < beatCycle.size() && i < inCycle.size())
        checkOutput($sformatf("full_lat%0d", i + 1), beatCycle[i], inCycle[i] + 1);
      else
        checkOutput($sformatf("full_lat%0d_missing", i + 1), 0, 1);
    end
    checkLen("full", 256);

    // Backpressure with 40 bytes buffered
    clearQueues();
    m_ready = 1'b0;
    applyStimulus(mkBeat(8'h80, 20, 1'b1), 20, 1'b0);
    applyStimulus(mkBeat(8'h94, 20, 1'b1), 20, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_m_valid", m_valid, 1);
      checkOutput("bp_m_bytes", m_bytes, 32);
      checkOutput("bp_m_data", m_data, mkBeat(8'h80, 32, 1'b0));
      checkOutput("bp_s_ready", s_ready, 0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_rem_valid", m_valid, 0);
    checkOutput("bp_rem_bytes", m_bytes, 8);
    checkOutput("bp_rem_data", m_data, mkBeat(8'hA0, 8, 1'b0));
    @(posedge clk);
    #1;
    applyStimulus('0, 0, 1'b1);
    waitBeats(2);
    checkOutput("bp_beat_count", beatData.size(), 2);
    checkBeat("bp_b1", 0, mkBeat(8'h80, 32, 1'b0), 32, 0);
    checkBeat("bp_b2", 1, mkBeat(8'hA0, 8, 1'b0), 8, 1);
    checkLen("bp", 40);

    // Zero-length packet
    clearQueues();
    applyStimulus(mkBeat(8'h55, 32, 1'b0), 0, 1'b1);
    waitBeats(1);
    checkOutput("zero_beat_count", beatData.size(), 1);
    checkBeat("zero_b1", 0, '0, 0, 1);
    checkLen("zero", 0);

    // Oversized byte count clamps to a full beat
    clearQueues();
    applyStimulus(mkBeat(8'h10, 32, 1'b0), 40, 1'b1);
    waitBeats(1);
    checkOutput("clamp_beat_count", beatData.size(), 1);
    checkBeat("clamp_b1", 0, mkBeat(8'h10, 32, 1'b0), 32, 1);
    checkLen("clamp", 32);

    // Reset in the middle of a packet
    clearQueues();
    applyStimulus(mkBeat(8'h50, 20, 1'b1), 20, 1'b0);
    applyStimulus(mkBeat(8'h64, 20, 1'b1), 20, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_m_valid", m_valid, 0);
    checkOutput("mid_m_last", m_last, 0);
    checkOutput("mid_m_bytes", m_bytes, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_beat_count", beatData.size(), 0);
    checkOutput("mid_done_count", lenQ.size(), 0);
    checkOutput("mid_pkt_len", pkt_len, 0);
    applyStimulus(mkBeat(8'h30, 10, 1'b1), 10, 1'b1);
    waitBeats(1);
    checkOutput("post_beat_count", beatData.size(), 1);
    checkBeat("post_b1", 0, mkBeat(8'h30, 10, 1'b0), 10, 1);
    checkLen("post", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
